// File: rtl/fetch_unit.sv
// Instruction fetch and program-load sequencer for a 2^A-entry program memory.
// Run mode steps a PC and hands words to the decoder; load mode streams words into memory.
module fetch_unit #(
  parameter int N = 8,
  parameter int A = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         run,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  input  logic         load_last,
  output logic         load_done,
  output logic [A-1:0] mem_addr,
  output logic         mem_we,
  output logic [N-1:0] mem_d,
  output logic         mem_init,
  input  logic [N-1:0] mem_q,
  output logic [N-1:0] instr,
  output logic [A-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         jump_valid,
  input  logic [A-1:0] jump_target,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_CAPTURE,
    S_HOLD
  } state_e;

  localparam logic [A-1:0] LAST_ADDR = '1;

  state_e       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [A-1:0] load_ptr_q, load_ptr_d;
  logic [N-1:0] instr_q, instr_d;
  logic [A-1:0] instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         load_done_q, load_done_d;
  logic         handshake;

  assign handshake = instr_valid_q & instr_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_ptr_d    = load_ptr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    load_done_d   = 1'b0;
    mem_addr      = pc_q;
    mem_we        = 1'b0;
    mem_d         = '0;
    mem_init      = 1'b0;

    unique case (state_q)
      S_INIT: begin
        mem_init = 1'b1;
        mem_addr = '0;
        state_d  = S_IDLE;
      end

      S_IDLE: begin
        if (load_start) begin
          load_ptr_d = '0;
          state_d    = S_LOAD;
        end else if (run) begin
          state_d = S_ISSUE;
        end
      end

      S_LOAD: begin
        mem_addr = load_ptr_q;
        mem_d    = load_data;
        mem_we   = load_valid;
        if (load_valid) begin
          load_ptr_d = load_ptr_q + 1'b1;
          // The write to the top address ends the load even without load_last.
          if (load_last || (load_ptr_q == LAST_ADDR)) begin
            load_ptr_d  = '0;
            load_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        instr_d       = mem_q;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
        pc_d          = pc_q + 1'b1;
        state_d       = S_HOLD;
      end

      S_HOLD: begin
        if (handshake) begin
          instr_valid_d = 1'b0;
          if (jump_valid) pc_d = jump_target;
          state_d = run ? S_ISSUE : S_IDLE;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous to clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_INIT;
      pc_q          <= '0;
      load_ptr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      load_ptr_q    <= load_ptr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign load_done   = load_done_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for load/fetch/stall/jump,
// then hand sequences for wrap, 32-word load, run drop and reset recovery.
module tb_fetch_unit;

  typedef struct {
    logic       rst, run, ls, lv, ll;
    logic [7:0] ld;
    logic       rdy, jv;
    logic [4:0] jt;
  } in_t;

  typedef struct {
    logic       init, we;
    logic [4:0] addr;
    logic [7:0] d, ins;
    logic [4:0] ipc;
    logic       iv, ldn, bsy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       instr_ready = 1'b0, jump_valid = 1'b0;
  logic [4:0] jump_target = 5'd0;
  logic       load_done, mem_we, mem_init, instr_valid, busy;
  logic [4:0] mem_addr, instr_pc;
  logic [7:0] mem_d, instr;
  logic [7:0] mem_q = 8'h00;
  logic [7:0] mem [32] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clock = ~clock;

  fetch_unit #(.N(8), .A(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_done   (load_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_d       (mem_d),
    .mem_init    (mem_init),
    .mem_q       (mem_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .busy        (busy)
  );

  // Program memory: registered read, init clears only the output register.
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_d;
    mem_q <= mem_init ? 8'h00 : mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic in_t mi(input int rst, input int r, input int ls, input int lv,
                             input int ll, input int ld, input int rdy, input int jv,
                             input int jt);
    in_t v;
    v.rst = 1'(rst); v.run = 1'(r); v.ls = 1'(ls); v.lv = 1'(lv); v.ll = 1'(ll);
    v.ld = 8'(ld); v.rdy = 1'(rdy); v.jv = 1'(jv); v.jt = 5'(jt);
    return v;
  endfunction

  function automatic out_t mo(input int init, input int we, input int addr, input int d,
                              input int ins, input int ipc, input int iv, input int ldn,
                              input int bsy);
    out_t v;
    v.init = 1'(init); v.we = 1'(we); v.addr = 5'(addr); v.d = 8'(d); v.ins = 8'(ins);
    v.ipc = 5'(ipc); v.iv = 1'(iv); v.ldn = 1'(ldn); v.bsy = 1'(bsy);
    return v;
  endfunction

  task automatic add(input in_t a, input out_t b);
    vec_t v;
    v.i = a;
    v.o = b;
    tbl.push_back(v);
  endtask

  task automatic apply(input in_t v);
    reset = v.rst; run = v.run; load_start = v.ls; load_valid = v.lv; load_last = v.ll;
    load_data = v.ld; instr_ready = v.rdy; jump_valid = v.jv; jump_target = v.jt;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for instr_valid (bounded), checks latency and word, then hands it off.
  task automatic fetch(input string nm, input int epc, input int eins, input int elat,
                       input logic jv, input logic [4:0] jt, input logic run_after);
    int lat = 0;
    instr_ready = 1'b0;
    @(negedge clock);
    while (!instr_valid && lat < 20) begin
      lat++;
      @(negedge clock);
    end
    check($sformatf("%s.lat", nm), 32'(lat), 32'(elat));
    check($sformatf("%s.pc", nm), 32'(instr_pc), 32'(epc));
    check($sformatf("%s.instr", nm), 32'(instr), 32'(eins));
    instr_ready = 1'b1;
    jump_valid  = jv;
    jump_target = jt;
    run         = run_after;
    tick();
    instr_ready = 1'b0;
    jump_valid  = 1'b0;
  endtask

  initial begin
    //   in: rst run ls lv ll data rdy jv jt       out: init we addr d instr ipc iv ldn busy
    add(mi(1,0,0,0,0,8'h00,0,0,0),  mo(1,0, 0,8'h00,8'h00, 0,0,0,1));
    add(mi(0,0,0,0,0,8'h00,0,0,0),  mo(1,0, 0,8'h00,8'h00, 0,0,0,1));
    add(mi(0,0,0,0,0,8'h00,0,0,0),  mo(0,0, 0,8'h00,8'h00, 0,0,0,0));
    add(mi(0,1,1,0,0,8'h00,0,0,0),  mo(0,0, 0,8'h00,8'h00, 0,0,0,0));
    add(mi(0,0,0,1,0,8'hA1,0,0,0),  mo(0,1, 0,8'hA1,8'h00, 0,0,0,1));
    add(mi(0,0,0,1,0,8'hB2,0,0,0),  mo(0,1, 1,8'hB2,8'h00, 0,0,0,1));
    add(mi(0,0,0,0,0,8'h55,0,0,0),  mo(0,0, 2,8'h55,8'h00, 0,0,0,1));
    add(mi(0,0,0,1,0,8'hC3,0,0,0),  mo(0,1, 2,8'hC3,8'h00, 0,0,0,1));
    add(mi(0,0,0,1,1,8'hD4,0,0,0),  mo(0,1, 3,8'hD4,8'h00, 0,0,0,1));
    add(mi(0,0,0,0,0,8'h00,0,0,0),  mo(0,0, 0,8'h00,8'h00, 0,0,1,0));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 0,8'h00,8'h00, 0,0,0,0));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 0,8'h00,8'h00, 0,0,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 0,8'h00,8'h00, 0,0,0,1));
    add(mi(0,1,0,0,0,8'h00,1,0,0),  mo(0,0, 1,8'h00,8'hA1, 0,1,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 1,8'h00,8'hA1, 0,0,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 1,8'h00,8'hA1, 0,0,0,1));
    add(mi(0,1,0,0,0,8'h00,1,0,0),  mo(0,0, 2,8'h00,8'hB2, 1,1,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 2,8'h00,8'hB2, 1,0,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 2,8'h00,8'hB2, 1,0,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 3,8'h00,8'hC3, 2,1,0,1));
    for (int s = 0; s < 4; s++)
      add(mi(0,1,0,0,0,8'h00,0,1,7), mo(0,0, 3,8'h00,8'hC3, 2,1,0,1));
    add(mi(0,1,0,0,0,8'h00,1,0,0),  mo(0,0, 3,8'h00,8'hC3, 2,1,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 3,8'h00,8'hC3, 2,0,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0, 3,8'h00,8'hC3, 2,0,0,1));
    add(mi(0,1,0,0,0,8'h00,1,1,20), mo(0,0, 4,8'h00,8'hD4, 3,1,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0,20,8'h00,8'hD4, 3,0,0,1));
    add(mi(0,1,0,0,0,8'h00,0,0,0),  mo(0,0,20,8'h00,8'hD4, 3,0,0,1));
    add(mi(0,0,0,0,0,8'h00,1,0,0),  mo(0,0,21,8'h00,8'h00,20,1,0,1));
    add(mi(0,0,0,0,0,8'h00,0,0,0),  mo(0,0,21,8'h00,8'h00,20,0,0,0));

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i);
      @(negedge clock);
      check($sformatf("v%0d.init", k),  32'(mem_init),    32'(tbl[k].o.init));
      check($sformatf("v%0d.we", k),    32'(mem_we),      32'(tbl[k].o.we));
      check($sformatf("v%0d.addr", k),  32'(mem_addr),    32'(tbl[k].o.addr));
      check($sformatf("v%0d.d", k),     32'(mem_d),       32'(tbl[k].o.d));
      check($sformatf("v%0d.instr", k), 32'(instr),       32'(tbl[k].o.ins));
      check($sformatf("v%0d.ipc", k),   32'(instr_pc),    32'(tbl[k].o.ipc));
      check($sformatf("v%0d.valid", k), 32'(instr_valid), 32'(tbl[k].o.iv));
      check($sformatf("v%0d.ldone", k), 32'(load_done),   32'(tbl[k].o.ldn));
      check($sformatf("v%0d.busy", k),  32'(busy),        32'(tbl[k].o.bsy));
      tick();
    end
    apply(mi(0,0,0,0,0,0,0,0,0));

    // 32-word load without load_last: data = 7*addr+3, ends after address 31.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i * 7 + 3);
      @(negedge clock);
      check($sformatf("ld32.addr%0d", i), 32'(mem_addr), 32'(i));
      check($sformatf("ld32.we%0d", i),   32'(mem_we),   32'd1);
      tick();
    end
    load_valid = 1'b0;
    @(negedge clock);
    check("ld32.done",  32'(load_done), 32'd1);
    check("ld32.busy",  32'(busy),      32'd0);
    check("ld32.pc",    32'(mem_addr),  32'd21);
    tick();
    @(negedge clock);
    check("ld32.done_pulse", 32'(load_done), 32'd0);
    tick();

    // Jump to 30, then sequential fetch across the wrap with no stall.
    run = 1'b1;
    fetch("f21", 21, 8'h96, 3, 1'b1, 5'd30, 1'b1);
    fetch("f30", 30, 8'hD5, 2, 1'b0, 5'd0,  1'b1);
    fetch("f31", 31, 8'hDC, 2, 1'b0, 5'd0,  1'b1);
    fetch("f0",   0, 8'h03, 2, 1'b0, 5'd0,  1'b0);

    // run drops in ISSUE: the fetch still completes, then idle.
    run = 1'b1;
    tick();
    run = 1'b0;
    fetch("drop", 1, 8'h0A, 2, 1'b0, 5'd0, 1'b0);
    @(negedge clock);
    check("drop.busy",  32'(busy),        32'd0);
    check("drop.valid", 32'(instr_valid), 32'd0);
    check("drop.pc",    32'(mem_addr),    32'd2);
    tick();

    // Reset after two load writes.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h5A;
    tick();
    load_data  = 8'h6B;
    tick();
    load_valid = 1'b0;
    reset      = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rl.init",  32'(mem_init),    32'd1);
    check("rl.busy",  32'(busy),        32'd1);
    check("rl.valid", 32'(instr_valid), 32'd0);
    check("rl.instr", 32'(instr),       32'd0);
    check("rl.ldone", 32'(load_done),   32'd0);
    tick();
    @(negedge clock);
    check("rl.idle_init", 32'(mem_init), 32'd0);
    check("rl.idle_busy", 32'(busy),     32'd0);
    check("rl.pc",        32'(mem_addr), 32'd0);
    tick();

    // Reset while in CAPTURE discards the in-flight fetch.
    run = 1'b1;
    fetch("r0", 0, 8'h5A, 3, 1'b0, 5'd0, 1'b1);
    tick();
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rc.init",  32'(mem_init),    32'd1);
    check("rc.valid", 32'(instr_valid), 32'd0);
    check("rc.instr", 32'(instr),       32'd0);
    check("rc.ipc",   32'(instr_pc),    32'd0);
    tick();
    @(negedge clock);
    check("rc.pc",    32'(mem_addr), 32'd0);
    check("rc.busy",  32'(busy),     32'd0);
    tick();
    run = 1'b1;
    fetch("p0", 0, 8'h5A, 3, 1'b0, 5'd0, 1'b1);
    fetch("p1", 1, 8'h6B, 2, 1'b0, 5'd0, 1'b1);
    fetch("p2", 2, 8'h11, 2, 1'b0, 5'd0, 1'b0);
    @(negedge clock);
    check("end.busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
